s3g_tx: RTL



---
 rtl/s3g_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/s3g_tx.sv
// rtl/s3g_tx.sv - S3G response framer: D5, length, payload, Maxim CRC-8 into a byte UART.
// Optional S3G_TX_LEN_CHECK_EN rejects packets with len > 16 instead of clamping them.
module s3g_tx #(
    parameter logic [7:0] START_BYTE  = 8'hD5,
    parameter int         MAX_PAYLOAD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_packet_wr,
    input  logic [7:0] tx_payload_len,
    input  logic [7:0] tx_buf0,
    input  logic [7:0] tx_buf1,
    input  logic [7:0] tx_buf2,
    input  logic [7:0] tx_buf3,
    input  logic [7:0] tx_buf4,
    input  logic [7:0] tx_buf5,
    input  logic [7:0] tx_buf6,
    input  logic [7:0] tx_buf7,
    input  logic [7:0] tx_buf8,
    input  logic [7:0] tx_buf9,
    input  logic [7:0] tx_buf10,
    input  logic [7:0] tx_buf11,
    input  logic [7:0] tx_buf12,
    input  logic [7:0] tx_buf13,
    input  logic [7:0] tx_buf14,
    input  logic [7:0] tx_buf15,
    output logic       tx_busy,
    output logic       tx_drop,
    output logic [7:0] uart_data,
    output logic       uart_wr,
    input  logic       uart_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LEN, S_DATA, S_CRC, S_WAIT, S_DRAIN
    } state_t;

    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    state_t     state, state_n, after_wait, after_n;
    logic [7:0] len_q, len_n;
    logic [3:0] idx, idx_n;
    logic [7:0] crc, crc_n;
    logic [7:0] data_n;
    logic       wr_n, busy_n, drop_n, accept;
    logic [7:0] in_bytes [16];
    logic [7:0] pay_q    [16];

    assign in_bytes[0]  = tx_buf0;
    assign in_bytes[1]  = tx_buf1;
    assign in_bytes[2]  = tx_buf2;
    assign in_bytes[3]  = tx_buf3;
    assign in_bytes[4]  = tx_buf4;
    assign in_bytes[5]  = tx_buf5;
    assign in_bytes[6]  = tx_buf6;
    assign in_bytes[7]  = tx_buf7;
    assign in_bytes[8]  = tx_buf8;
    assign in_bytes[9]  = tx_buf9;
    assign in_bytes[10] = tx_buf10;
    assign in_bytes[11] = tx_buf11;
    assign in_bytes[12] = tx_buf12;
    assign in_bytes[13] = tx_buf13;
    assign in_bytes[14] = tx_buf14;
    assign in_bytes[15] = tx_buf15;

    // Maxim/Dallas CRC-8, reflected polynomial 0x8C, data bits taken LSB first
    function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
            else             c = c >> 1;
        end
        return c;
    endfunction

    always_comb begin
        state_n = state;
        after_n = after_wait;
        len_n   = len_q;
        idx_n   = idx;
        crc_n   = crc;
        data_n  = uart_data;
        wr_n    = 1'b0;
        busy_n  = tx_busy;
        drop_n  = tx_packet_wr && (state != S_IDLE);
        accept  = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_packet_wr) begin
`ifdef S3G_TX_LEN_CHECK_EN
                    if (tx_payload_len > MAX_LEN) drop_n = 1'b1;
                    else                          accept = 1'b1;
`else
                    accept = 1'b1;
`endif
                end
                if (accept) begin
                    state_n = S_START;
                    busy_n  = 1'b1;
                    crc_n   = 8'h00;
                    idx_n   = 4'd0;
                    len_n   = (tx_payload_len > MAX_LEN) ? MAX_LEN : tx_payload_len;
                end
            end
            S_START: if (!uart_busy) begin
                wr_n    = 1'b1;
                data_n  = START_BYTE;
                state_n = S_WAIT;
                after_n = S_LEN;
            end
            S_LEN: if (!uart_busy) begin
                wr_n    = 1'b1;
                data_n  = len_q;
                state_n = S_WAIT;
                after_n = (len_q == 8'd0) ? S_CRC : S_DATA;
            end
            S_DATA: if (!uart_busy) begin
                wr_n    = 1'b1;
                data_n  = pay_q[idx];
                crc_n   = crc8_byte(crc, pay_q[idx]);
                state_n = S_WAIT;
                if ({4'd0, idx} == len_q - 8'd1) begin
                    after_n = S_CRC;
                end else begin
                    after_n = S_DATA;
                    idx_n   = idx + 4'd1;
                end
            end
            S_CRC: if (!uart_busy) begin
                wr_n    = 1'b1;
                data_n  = crc;
                state_n = S_WAIT;
                after_n = S_DRAIN;
            end
            // one dead cycle so the UART's busy response is visible before the next write
            S_WAIT: state_n = after_wait;
            S_DRAIN: if (!uart_busy) begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            after_wait <= S_IDLE;
            len_q      <= 8'd0;
            idx        <= 4'd0;
            crc        <= 8'd0;
            uart_data  <= 8'd0;
            uart_wr    <= 1'b0;
            tx_busy    <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            state      <= state_n;
            after_wait <= after_n;
            len_q      <= len_n;
            idx        <= idx_n;
            crc        <= crc_n;
            uart_data  <= data_n;
            uart_wr    <= wr_n;
            tx_busy    <= busy_n;
            tx_drop    <= drop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 16; i++) pay_q[i] <= in_bytes[i];
        end
    end

endmodule
